// File: rtl/weight_rom_sequencer.sv
// weight_rom_sequencer: steps 64 weight ROM lanes through their 27 kernel weights once per output pixel
module weight_rom_sequencer #(
    parameter int NUM   = 64,
    parameter int ADDR  = 11,
    parameter int KSIZE = 27,
    parameter int PIX_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] num_pixels,
    input  logic             ready,
    output logic [ADDR-1:0]  address [0:NUM-1],
    output logic             valid,
    output logic             first_k,
    output logic             last_k,
    output logic [PIX_W-1:0] pixel_idx,
    output logic             busy,
    output logic             done
);
    localparam int KW = KSIZE > 1 ? $clog2(KSIZE) : 1;
    localparam logic [KW-1:0] KLAST = KW'(KSIZE - 1);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0] state, nstate;
    logic [KW-1:0] k, nk;
    logic [PIX_W-1:0] count, np;
    logic go, empty, acc, kend, fin, nvalid;
    if (NUM * KSIZE > 2 ** ADDR) begin : g_width_err
        $error("weight_rom_sequencer: NUM*KSIZE exceeds the ROM address space");
    end
    // next kernel index, pixel index and state; outputs are registered from these
    always_comb begin
        go = state == IDLE && start && num_pixels != '0;
        empty = state == IDLE && start && num_pixels == '0;
        acc = state == RUN && ready;
        kend = k == KLAST;
        fin = acc && kend && pixel_idx == count - PIX_W'(1);
        nvalid = go || (state == RUN && !fin);
        nk = go ? '0 : (acc && !fin) ? (kend ? '0 : k + KW'(1)) : k;
        np = go ? '0 : (acc && kend && !fin) ? pixel_idx + PIX_W'(1) : pixel_idx;
        nstate = go ? RUN : (empty || fin) ? DONE : state == DONE ? IDLE : state;
    end
    // sequencer state and beat qualifiers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k <= '0;
            count <= '0;
            pixel_idx <= '0;
            valid <= 1'b0;
            busy <= 1'b0;
            first_k <= 1'b0;
            last_k <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= nstate;
            k <= nk;
            count <= go ? num_pixels : count;
            pixel_idx <= np;
            valid <= nvalid;
            busy <= nvalid;
            first_k <= nvalid && nk == '0;
            last_k <= nvalid && nk == KLAST;
            done <= empty || fin;
        end
    end
    for (genvar i = 0; i < NUM; i++) begin : g_lane
        localparam logic [ADDR-1:0] OFF = ADDR'(i * KSIZE);
        // lane address is its constant filter base plus the shared kernel index
        always_ff @(posedge clk) begin
            if (rst) address[i] <= '0;
            else address[i] <= OFF + ADDR'(nk);
        end
    end
endmodule

// File: tb/tb_weight_rom_sequencer.sv
// tb_weight_rom_sequencer: directed self-checking bench for weight_rom_sequencer
module tb_weight_rom_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [15:0] num_pixels = '0;
    logic ready = 1'b1;
    logic [10:0] address [0:63];
    logic valid, first_k, last_k, busy, done;
    logic [15:0] pixel_idx;
    int checks = 0;
    int errors = 0;

    weight_rom_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .num_pixels(num_pixels), .ready(ready),
        .address(address), .valid(valid), .first_k(first_k), .last_k(last_k),
        .pixel_idx(pixel_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({valid, busy, first_k, last_k, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", {valid, busy, first_k, last_k, done});
        end
        checks++;
        if (address[0] !== 11'd0 || address[63] !== 11'd0 || pixel_idx !== 16'd0) begin
            errors++;
            $display("FAIL reset_data got a0=%0d a63=%0d pix=%0d want 0 0 0", address[0], address[63], pixel_idx);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        ready = 1'b1;
        num_pixels = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            checks++;
            if ({valid, busy, done} !== 3'b110 || first_k !== (c == 1) || last_k !== (c == 27)) begin
                errors++;
                $display("FAIL single_flags c=%0d got v/b/d=%b f=%b l=%b want 110 f=%b l=%b",
                         c, {valid, busy, done}, first_k, last_k, c == 1, c == 27);
            end
            checks++;
            if (address[0] !== 11'(c - 1) || address[1] !== 11'(27 + c - 1) || address[63] !== 11'(1701 + c - 1)) begin
                errors++;
                $display("FAIL single_addr c=%0d got %0d %0d %0d want %0d %0d %0d",
                         c, address[0], address[1], address[63], c - 1, 26 + c, 1700 + c);
            end
            tick();
        end
        checks++;
        if ({valid, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL single_done got v/b/d=%b want 001", {valid, busy, done});
        end
        tick();
        checks++;
        if ({valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL single_idle got v/b/d=%b want 000", {valid, busy, done});
        end
    endtask

    task automatic test_multi();
        int ndone = 0;
        num_pixels = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 81; b++) begin
            checks++;
            if (valid !== 1'b1 || address[5] !== 11'(135 + b % 27) || pixel_idx !== 16'(b / 27)
                || first_k !== (b % 27 == 0) || last_k !== (b % 27 == 26)) begin
                errors++;
                $display("FAIL multi_beat b=%0d got v=%b a5=%0d pix=%0d f=%b l=%b want v=1 a5=%0d pix=%0d",
                         b, valid, address[5], pixel_idx, first_k, last_k, 135 + b % 27, b / 27);
            end
            if (done) ndone++;
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            if (done) ndone++;
            tick();
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL multi_done_count got %0d want 1", ndone);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        int cyc = 0;
        num_pixels = 16'd2;
        start = 1'b1;
        ready = 1'b1;
        tick();
        start = 1'b0;
        while (n < 54 && cyc < 1000) begin
            checks++;
            if (valid !== 1'b1 || address[0] !== 11'(n % 27) || address[2] !== 11'(54 + n % 27)
                || pixel_idx !== 16'(n / 27) || first_k !== (n % 27 == 0) || last_k !== (n % 27 == 26)) begin
                errors++;
                $display("FAIL stall_beat n=%0d got v=%b a0=%0d a2=%0d pix=%0d f=%b l=%b want v=1 a0=%0d a2=%0d pix=%0d",
                         n, valid, address[0], address[2], pixel_idx, first_k, last_k, n % 27, 54 + n % 27, n / 27);
            end
            ready = 1'($urandom_range(0, 1));
            if (ready) n++;
            cyc++;
            tick();
        end
        checks++;
        if (n !== 54) begin
            errors++;
            $display("FAIL stall_budget got %0d beats want 54", n);
        end
        checks++;
        if ({valid, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL stall_done got v/b/d=%b want 001", {valid, busy, done});
        end
        ready = 1'b1;
        tick();
    endtask

    task automatic test_zero();
        num_pixels = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({valid, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL zero_done got v/b/d=%b want 001", {valid, busy, done});
        end
        tick();
        checks++;
        if ({valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL zero_idle got v/b/d=%b want 000", {valid, busy, done});
        end
    endtask

    task automatic test_ignore_and_reset();
        num_pixels = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b <= 42; b++) begin
            if (b == 37) begin
                start = 1'b1;
                num_pixels = 16'd1;
            end
            checks++;
            if (valid !== 1'b1 || address[3] !== 11'(81 + b % 27) || pixel_idx !== 16'(b / 27)) begin
                errors++;
                $display("FAIL ignore_beat b=%0d got v=%b a3=%0d pix=%0d want v=1 a3=%0d pix=%0d",
                         b, valid, address[3], pixel_idx, 81 + b % 27, b / 27);
            end
            if (b < 42) tick();
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({valid, busy, first_k, last_k, done} !== 5'b0 || address[3] !== 11'd0 || address[63] !== 11'd0 || pixel_idx !== 16'd0) begin
            errors++;
            $display("FAIL midreset got flags=%b a3=%0d a63=%0d pix=%0d want 0",
                     {valid, busy, first_k, last_k, done}, address[3], address[63], pixel_idx);
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle got v=%b want 0", valid);
        end
        num_pixels = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (valid !== 1'b1 || first_k !== 1'b1 || address[3] !== 11'd81 || pixel_idx !== 16'd0) begin
            errors++;
            $display("FAIL restart got v=%b f=%b a3=%0d pix=%0d want 1 1 81 0", valid, first_k, address[3], pixel_idx);
        end
        for (int c = 0; c < 27; c++) tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done got %b want 1", done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        num_pixels = 16'd1;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 87; c++) begin
            int ph;
            ph = (c - 1) % 29;
            if (c == 87) start = 1'b0;
            checks++;
            if (valid !== (ph < 27) || done !== (ph == 27) || (ph < 27 && address[0] !== 11'(ph))) begin
                errors++;
                $display("FAIL b2b c=%0d got v=%b d=%b a0=%0d want v=%b d=%b a0=%0d",
                         c, valid, done, address[0], ph < 27, ph == 27, ph);
            end
            if (done) ndone++;
            tick();
        end
        checks++;
        if (ndone !== 3) begin
            errors++;
            $display("FAIL b2b_done_count got %0d want 3", ndone);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_zero();
        test_ignore_and_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/weight_rom_sequencer.md
Name: weight_rom_sequencer

Overview:
Address generator and sequencer for the first-layer weight ROM (64 parallel combinational read lanes, 3x3x3 kernel per filter, 1728 entries). It steps every lane through its filter's 27 kernel weights once per output pixel. The convolution engine is the consumer, and each beat is paced by a valid/ready handshake. The ROM is combinational, so ROM data is valid in the same cycle as the address this block drives.

Parameters:
NUM, 64, number of parallel ROM lanes (filters)
ADDR, 11, ROM address width
KSIZE, 27, weights per filter (3*3*3); lane i occupies ROM entries i*KSIZE .. i*KSIZE+KSIZE-1
PIX_W, 16, width of pixel count/index

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a pass; sampled only in IDLE
num_pixels  in  PIX_W  output pixels in the pass; latched when start is accepted
ready  in  1  consumer accepts the current beat
address  out  [ADDR-1:0] x NUM (unpacked [0:NUM-1])  per-lane ROM address, registered
valid  out  1  address/beat valid
first_k  out  1  beat is k==0 (consumer clears accumulator)
last_k  out  1  beat is k==KSIZE-1 (consumer closes accumulation)
pixel_idx  out  PIX_W  pixel index of the current beat
busy  out  1  high while in RUN
done  out  1  one-cycle pulse at pass end

Behaviour:
- Reset, in any state and mid-pass: state to IDLE. address[*]=0, valid=0, first_k=0, last_k=0, pixel_idx=0, busy=0, done=0. The latched count is cleared.
- FSM states are IDLE, RUN and DONE.
- IDLE, start=1, num_pixels>0: latch num_pixels, set k=0 and pixel=0, go to RUN. The first valid beat appears in the next cycle.
- IDLE, start=1, num_pixels=0: go to DONE. No valid beat is produced.
- RUN: valid=1 and busy=1.
  - Beat accepted when valid&&ready.
  - ready=0: address, first_k, last_k and pixel_idx hold stable.
  - Accepted beat with k<KSIZE-1: k increments.
  - Accepted beat with k==KSIZE-1 and pixel<count-1: k wraps to 0, pixel increments.
  - Accepted beat with k==KSIZE-1 and pixel==count-1: go to DONE.
- DONE: valid=0, busy=0, done=1 for exactly one cycle. The next state is always IDLE.
- start is ignored in RUN and DONE. A start asserted while busy is dropped and is not queued.
- Address rule: address[i] = i*KSIZE + k, computed at ADDR width. All lanes update in the same cycle. Lane offsets i*KSIZE are elaboration-time constants and use no multipliers.
- Width rule: NUM*KSIZE <= 2**ADDR. Violation is an elaboration error. With the defaults, the maximum address is 63*27+26=1727.
- first_k=(k==0) and last_k=(k==KSIZE-1), both qualified by valid.
- Throughput: one beat per cycle with ready held high. A pass takes num_pixels*KSIZE beats, then one DONE cycle.

Test Plan:
- rst, num_pixels=1, start, ready=1 constantly -> valid cycles 1..27. address[0]=0..26, address[1]=27..53, address[63]=1701..1727. first_k only at cycle 1, last_k only at cycle 27. done at cycle 28, busy=0 from cycle 28.
- num_pixels=3, ready=1 -> 81 beats. pixel_idx is 0 for beats 1-27, 1 for 28-54, 2 for 55-81. k wraps 26->0 at each boundary with first_k re-asserted. One done pulse.
- num_pixels=2 with ready toggling 1,0,0,1 pseudo-randomly -> outputs hold stable while ready=0. Exactly 54 accepted beats in order, and no address is skipped or repeated.
- num_pixels=0, start -> no valid beat. done pulses one cycle after start. Return to IDLE.
- Pass running at k=10, pixel=1 with start re-asserted -> start ignored, the sequence continues unchanged. Then assert rst at k=15 -> next cycle all outputs are 0 and the state is IDLE. A fresh start restarts at k=0, pixel=0.
- start held high continuously with num_pixels=1 -> back-to-back passes, each 27 beats, separated by a DONE cycle and an IDLE cycle. done pulses once per pass.
